// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two
// valid/ready requesters and returns each captured result to its owner only.
module alu_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          INIT_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  logic             prio;
  logic             owner;
  logic             grant_c;
  logic             accept_c;
  logic             legal_c;
  logic             rsp_take_c;
  logic [WIDTH-1:0] result_c;

  // Grant the lone valid requester, or the favoured one under contention
  always_comb begin
    grant_c = prio;
    if (req0_valid && !req1_valid) begin
      grant_c = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant_c = 1'b1;
    end
  end

  // Ready is only offered in IDLE and is held low while reset is asserted
  assign req0_ready = rst_n && (state == S_IDLE) && req0_valid && !grant_c;
  assign req1_ready = rst_n && (state == S_IDLE) && req1_valid &&  grant_c;
  assign accept_c   = req0_ready || req1_ready;

  // Supported op codes pass the ALU result through; anything else reads as zero
  always_comb begin
    case (alu_ctrl)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: legal_c = 1'b1;
      default:                                 legal_c = 1'b0;
    endcase
    result_c = legal_c ? alu_out : '0;
  end

  // Response handshake of the current owner
  assign rsp_take_c = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  // Sequencer: accept in IDLE, capture in EXEC, hold the response in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      prio        <= INIT_PRIO;
      owner       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= 3'b000;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
      rsp1_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            owner    <= grant_c;
            prio     <= ~grant_c;
            alu_a    <= grant_c ? req1_a  : req0_a;
            alu_b    <= grant_c ? req1_b  : req0_b;
            alu_ctrl <= grant_c ? req1_op : req0_op;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (owner) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= result_c;
            rsp1_zero   <= (result_c == '0);
            rsp1_err    <= ~legal_c;
          end else begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= result_c;
            rsp0_zero   <= (result_c == '0);
            rsp0_err    <= ~legal_c;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_take_c) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: external ALU model, response scoreboard,
// latency/fairness/backpressure/reset checks.
module tb_alu_arbiter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [2:0]   req0_op, req1_op, alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_out;

  alu_arbiter #(.WIDTH(W), .INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // External ALU; unsupported codes produce a nonzero value the arbiter must mask
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b101:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_out = alu_a ^ alu_b ^ 32'hdead_0001;
    endcase
  end

  typedef struct {
    int           owner;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           tick;
  } exp_t;

  exp_t   sb[$];
  int     grants[$];
  int     passed = 0;
  int     total  = 0;
  int     cyc    = 0;
  logic [1:0] prev_rv = 2'b00;
  logic [1:0] acc     = 2'b00;
  logic [1:0] seen_rv = 2'b00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op);
    exp_t e;
    e.owner = n;
    e.err   = 1'b0;
    case (op)
      3'b000:  e.res = a + b;
      3'b001:  e.res = a - b;
      3'b010:  e.res = a & b;
      3'b011:  e.res = a | b;
      3'b101:  e.res = (a < b) ? 32'd1 : 32'd0;
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    e.zero = (e.res == '0);
    e.tick = cyc;
    return e;
  endfunction

  task automatic observe(input int n, input logic [W-1:0] res, input logic z, input logic e,
                         input logic rdy);
    exp_t x;
    seen_rv[n] = 1'b1;
    if (sb.size() == 0) begin
      chk("rsp_without_request", 64'(sb.size()), 64'd1);
      return;
    end
    if (!prev_rv[n]) chk("latency", 64'(cyc), 64'(sb[0].tick + 2));
    if (rdy) begin
      x = sb.pop_front();
      chk("rsp_owner", 64'(n), 64'(x.owner));
      chk("rsp_result", 64'(res), 64'(x.res));
      chk("rsp_zero", 64'(z), 64'(x.zero));
      chk("rsp_err", 64'(e), 64'(x.err));
    end
  endtask

  // One cycle: settle, monitor handshakes that the next rising edge will commit, advance
  task automatic tick();
    #1;
    chk("ready_exclusive", 64'(req0_ready & req1_ready), 64'd0);
    if (req0_valid && req0_ready) begin
      sb.push_back(model(0, req0_a, req0_b, req0_op)); grants.push_back(0); acc[0] = 1'b1;
    end
    if (req1_valid && req1_ready) begin
      sb.push_back(model(1, req1_a, req1_b, req1_op)); grants.push_back(1); acc[1] = 1'b1;
    end
    if (rsp0_valid && rsp1_valid) chk("rsp_exclusive", 64'(rsp0_valid & rsp1_valid), 64'd0);
    if (rsp0_valid) observe(0, rsp0_result, rsp0_zero, rsp0_err, rsp0_ready);
    if (rsp1_valid) observe(1, rsp1_result, rsp1_zero, rsp1_err, rsp1_ready);
    prev_rv = {rsp1_valid, rsp0_valid};
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op);
    int k;
    acc = 2'b00;
    if (n == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    k = 0;
    while (!acc[n] && k < 20) begin tick(); k++; end
    if (!acc[n]) chk("accept_timeout", 64'(acc[n]), 64'd1);
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || rsp0_valid || rsp1_valid) && k < 40) begin tick(); k++; end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("rst_rsp0_result", 64'(rsp0_result), 64'd0);
    chk("rst_rsp1_result", 64'(rsp1_result), 64'd0);
    chk("rst_rsp_flags", 64'({rsp0_zero, rsp0_err, rsp1_zero, rsp1_err}), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
  endtask

  // Reset held with a valid request present; released on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_vals();
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete(); grants.delete();
    prev_rv = 2'b00;
  endtask

  initial begin
    logic [W-1:0] held;
    int k;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;

    // Reset values, then contention from both sides: strict 0,1,0,1 alternation
    do_reset();
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
    req1_a = 32'hf0; req1_b = 32'h0f; req1_op = 3'b011;
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0;
    while (grants.size() < 4 && k < 40) begin tick(); k++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant_count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", 64'(grants[i]), 64'(i % 2));
    drain();

    // Single add from requester 0 after a fresh reset
    do_reset();
    issue(0, 32'd5, 32'd7, 3'b000);
    drain();
    chk("add_result_held", 64'(rsp0_result), 64'd12);
    chk("add_zero_held", 64'(rsp0_zero), 64'd0);

    // Requester 1 subtract to zero; requester 0 stays silent
    seen_rv = 2'b00;
    issue(1, 32'd9, 32'd9, 3'b001);
    drain();
    chk("sub_rsp0_silent", 64'(seen_rv[0]), 64'd0);
    chk("sub_zero_held", 64'(rsp1_zero), 64'd1);

    // Unsupported op flags an error and forces zero; next legal op clears it
    issue(0, 32'd3, 32'd4, 3'b110);
    drain();
    chk("illegal_err_held", 64'(rsp0_err), 64'd1);
    issue(0, 32'd6, 32'd3, 3'b010);
    drain();
    chk("legal_after_err", 64'(rsp0_err), 64'd0);
    issue(1, 32'd2, 32'd9, 3'b101);
    drain();
    chk("slt_result_held", 64'(rsp1_result), 64'd1);

    // Unbounded backpressure on requester 0 blocks requester 1
    rsp0_ready = 1'b0;
    issue(0, 32'h1234, 32'h1, 3'b000);
    k = 0;
    while (!rsp0_valid && k < 10) begin tick(); k++; end
    held = rsp0_result;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_op = 3'b001;
    acc = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_req1_ready", 64'(req1_ready), 64'd0);
      chk("bp_rsp0_valid", 64'(rsp0_valid), 64'd1);
      chk("bp_rsp0_result", 64'(rsp0_result), 64'(held));
    end
    chk("bp_held_value", 64'(held), 64'h1235);
    rsp0_ready = 1'b1;
    tick();
    #1;
    chk("bp_release_req1_ready", 64'(req1_ready), 64'd1);
    tick();
    chk("bp_req1_accepted", 64'(acc[1]), 64'd1);
    req1_valid = 1'b0;
    drain();

    // Asynchronous reset while the op is in EXEC; it must never come back
    issue(0, 32'h55, 32'haa, 3'b011);
    req1_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    sb.delete();
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_rv = 2'b00;
    seen_rv = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_op_dropped", 64'(seen_rv), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
